// File: rtl/mem_stage_pkg.sv
// ============================================================================
//  Module      : mem_stage_pkg
//  Description : Shared op encodings, MEM FSM state encodings and access-size
//                helpers for the MEM pipeline stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_stage_pkg;

    // Op encodings presented by EX on op_i
    localparam logic [7:0] c_op_nop = 8'h00;
    localparam logic [7:0] c_op_add = 8'h01;
    localparam logic [7:0] c_op_lb  = 8'h10;
    localparam logic [7:0] c_op_lbu = 8'h11;
    localparam logic [7:0] c_op_lh  = 8'h12;
    localparam logic [7:0] c_op_lhu = 8'h13;
    localparam logic [7:0] c_op_lw  = 8'h14;
    localparam logic [7:0] c_op_sb  = 8'h18;
    localparam logic [7:0] c_op_sh  = 8'h19;
    localparam logic [7:0] c_op_sw  = 8'h1A;

    // MEM FSM state encodings
    localparam logic [0:0] c_mem_idle = 1'b0;
    localparam logic [0:0] c_mem_busy = 1'b1;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } acc_size_e;

    function automatic acc_size_e f_size(input logic [7:0] op);
        case (op)
            c_op_lb, c_op_lbu, c_op_sb: f_size = SZ_BYTE;
            c_op_lh, c_op_lhu, c_op_sh: f_size = SZ_HALF;
            c_op_lw, c_op_sw:           f_size = SZ_WORD;
            default:                    f_size = SZ_NONE;
        endcase
    endfunction

    function automatic logic f_is_store(input logic [7:0] op);
        f_is_store = (op == c_op_sb) || (op == c_op_sh) || (op == c_op_sw);
    endfunction

    function automatic logic f_is_mem(input logic [7:0] op);
        f_is_mem = (f_size(op) != SZ_NONE);
    endfunction

    function automatic logic f_misaligned(input logic [7:0] op, input logic [1:0] ea_lo);
        case (f_size(op))
            SZ_HALF: f_misaligned = ea_lo[0];
            SZ_WORD: f_misaligned = (ea_lo != 2'b00);
            default: f_misaligned = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_align.sv
// ============================================================================
//  Module      : mem_lane_align
//  Description : Combinational byte-lane steering. Builds store byte enables
//                and lane-replicated write data, and extracts/extends load
//                data, all from the op and the low two effective-address bits.
//  Ports       : op, ea_lo, st_data, rdata (in); be, wdata, ld_data (out)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [7:0]  op,
    input  logic [1:0]  ea_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_signed;

    always_comb begin
        w_byte   = 8'(rdata >> {ea_lo, 3'b000});
        w_half   = ea_lo[1] ? rdata[31:16] : rdata[15:0];
        w_signed = (op == c_op_lb) || (op == c_op_lh);
        be       = 4'b0000;
        wdata    = 32'h0;
        ld_data  = 32'h0;
        case (f_size(op))
            SZ_BYTE: begin
                be      = 4'b0001 << ea_lo;
                wdata   = {4{st_data[7:0]}};
                ld_data = {{24{w_signed & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                be      = ea_lo[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{st_data[15:0]}};
                ld_data = {{16{w_signed & w_half[15]}}, w_half};
            end
            SZ_WORD: begin
                be      = 4'b1111;
                wdata   = st_data;
                ld_data = rdata;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
//  Module      : mem_stage
//  Description : MEM pipeline stage. Non-memory ops pass to registered WB in
//                one cycle; loads/stores run one req/ack access at a time,
//                stalling upstream until ack or timeout abort.
//  Parameters  : TIMEOUT_CYC - BUSY cycles without ack before abort (0 = off)
//  Config      : MEM_ALIGN_CHECK_EN - reject misaligned half/word accesses
//                with a bus_err pulse instead of issuing a bus request
//  Ports       : EX side  instr_i, op_i, reg1_i, reg2_i, we_i, write_addr_i,
//                         write_data_i, stall_req
//                Bus side mem_req, mem_we, mem_addr, mem_be, mem_wdata,
//                         mem_rdata, mem_ack
//                WB side  wb_we, wb_addr, wb_data, bus_err
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_i,
    input  logic [7:0]  op_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic        we_i,
    input  logic [4:0]  write_addr_i,
    input  logic [31:0] write_data_i,
    output logic        stall_req,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        bus_err
);

    localparam int c_cnt_w = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [0:0]         r_state;
    logic [0:0]         w_next_state;
    logic [7:0]         r_op;
    logic [31:0]        r_ea;
    logic               r_we;
    logic [4:0]         r_waddr;
    logic [3:0]         r_be;
    logic [31:0]        r_wdata;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_wb_we;
    logic [4:0]         r_wb_addr;
    logic [31:0]        r_wb_data;
    logic               r_bus_err;

    logic [31:0]        w_ea;
    logic               w_is_mem;
    logic               w_misalign;
    logic               w_accept;
    logic               w_timeout;
    logic               w_busy;
    logic [7:0]         w_lane_op;
    logic [1:0]         w_lane_ea;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_ld_data;
    logic               w_unused;

    assign w_unused = &{1'b0, instr_i[31:16]};

    assign w_ea     = reg1_i + {{16{instr_i[15]}}, instr_i[15:0]};
    assign w_is_mem = f_is_mem(op_i);
    assign w_busy   = (r_state == c_mem_busy);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = f_misaligned(op_i, w_ea[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_accept = !w_busy && w_is_mem && !w_misalign;

    generate
        if (TIMEOUT_CYC > 0) begin : g_timeout
            // r_cnt holds the number of already-elapsed ack-less BUSY cycles
            assign w_timeout = w_busy && !mem_ack && (r_cnt == c_cnt_w'(TIMEOUT_CYC - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    // One lane aligner: while IDLE it shapes the incoming store from EX; while
    // BUSY it extracts the load using the latched op and address.
    assign w_lane_op = w_busy ? r_op      : op_i;
    assign w_lane_ea = w_busy ? r_ea[1:0] : w_ea[1:0];

    mem_lane_align u_lane (
        .op      (w_lane_op),
        .ea_lo   (w_lane_ea),
        .st_data (reg2_i),
        .rdata   (mem_rdata),
        .be      (w_be),
        .wdata   (w_wdata),
        .ld_data (w_ld_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_mem_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_mem_idle: if (w_accept)             w_next_state = c_mem_busy;
            c_mem_busy: if (mem_ack || w_timeout) w_next_state = c_mem_idle;
            default:                              w_next_state = c_mem_idle;
        endcase
    end

    // FSM outputs. The abort cycle also releases the stall so EX moves past
    // the failed access rather than re-issuing it forever.
    always_comb begin
        stall_req = 1'b0;
        mem_req   = 1'b0;
        case (r_state)
            c_mem_idle: stall_req = w_accept;
            c_mem_busy: begin
                mem_req   = 1'b1;
                stall_req = !(mem_ack || w_timeout);
            end
            default: ;
        endcase
        if (rst) begin
            stall_req = 1'b0;
        end
    end

    // Access latch, timeout counter and writeback registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= c_op_nop;
            r_ea      <= 32'h0;
            r_we      <= 1'b0;
            r_waddr   <= 5'h0;
            r_be      <= 4'h0;
            r_wdata   <= 32'h0;
            r_cnt     <= '0;
            r_wb_we   <= 1'b0;
            r_wb_addr <= 5'h0;
            r_wb_data <= 32'h0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            if (!w_busy) begin
                r_cnt <= '0;
                if (!w_is_mem) begin
                    r_wb_we   <= we_i;
                    r_wb_addr <= write_addr_i;
                    r_wb_data <= write_data_i;
                end else if (w_misalign) begin
                    r_wb_we   <= 1'b0;
                    r_bus_err <= 1'b1;
                end else begin
                    r_op    <= op_i;
                    r_ea    <= w_ea;
                    r_we    <= we_i;
                    r_waddr <= write_addr_i;
                    r_be    <= w_be;
                    r_wdata <= w_wdata;
                    r_wb_we <= 1'b0;
                end
            end else if (mem_ack) begin
                r_cnt     <= '0;
                r_wb_we   <= r_we && !f_is_store(r_op);
                r_wb_addr <= r_waddr;
                r_wb_data <= w_ld_data;
            end else if (w_timeout) begin
                r_cnt     <= '0;
                r_wb_we   <= 1'b0;
                r_bus_err <= 1'b1;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
                r_wb_we <= 1'b0;
            end
        end
    end

    assign mem_we    = w_busy && f_is_store(r_op);
    assign mem_addr  = {r_ea[31:2], 2'b00};
    assign mem_be    = r_be;
    assign mem_wdata = r_wdata;
    assign wb_we     = r_wb_we;
    assign wb_addr   = r_wb_addr;
    assign wb_data   = r_wb_data;
    assign bus_err   = r_bus_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage: table of single accesses
//                with a writeback scoreboard, plus hand sequences for timeout,
//                ack at the timeout limit, reset mid-access and alignment.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_i;
    logic [7:0]  op_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic        we_i;
    logic [4:0]  write_addr_i;
    logic [31:0] write_data_i;
    logic        stall_req;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        bus_err;

    mem_stage #(.TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_i      (instr_i),
        .op_i         (op_i),
        .reg1_i       (reg1_i),
        .reg2_i       (reg2_i),
        .we_i         (we_i),
        .write_addr_i (write_addr_i),
        .write_data_i (write_data_i),
        .stall_req    (stall_req),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    wb_t sb_q[$];

    typedef struct {
        logic [7:0]  op;
        logic [31:0] reg1;
        logic [15:0] off;
        logic [31:0] reg2;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] ex_data;
        int          ack_dly;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_wb_we;
        logic [31:0] exp_wb_data;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic tb_is_store(input logic [7:0] op);
        return (op == c_op_sb) || (op == c_op_sh) || (op == c_op_sw);
    endfunction

    function automatic logic tb_is_mem(input logic [7:0] op);
        return tb_is_store(op) || (op == c_op_lb) || (op == c_op_lbu) ||
               (op == c_op_lh) || (op == c_op_lhu) || (op == c_op_lw);
    endfunction

    function automatic vec_t mk(
        input logic [7:0] op, input logic [31:0] reg1, input logic [15:0] off,
        input logic [31:0] reg2, input logic we, input logic [4:0] waddr,
        input logic [31:0] ex_data, input int ack_dly, input logic [31:0] rdata,
        input logic [31:0] exp_addr, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
        input logic exp_wb_we, input logic [31:0] exp_wb_data);
        vec_t v;
        v.op = op; v.reg1 = reg1; v.off = off; v.reg2 = reg2; v.we = we;
        v.waddr = waddr; v.ex_data = ex_data; v.ack_dly = ack_dly; v.rdata = rdata;
        v.exp_addr = exp_addr; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
        v.exp_wb_we = exp_wb_we; v.exp_wb_data = exp_wb_data;
        return v;
    endfunction

    task automatic drive(input logic [7:0] op, input logic [31:0] reg1, input logic [15:0] off,
                         input logic [31:0] reg2, input logic we, input logic [4:0] waddr,
                         input logic [31:0] data);
        op_i = op; reg1_i = reg1; instr_i = {16'h0, off}; reg2_i = reg2;
        we_i = we; write_addr_i = waddr; write_data_i = data;
    endtask

    // Idle filler: no writeback, but non-zero data so stale wb_data is visible
    task automatic drive_nop();
        drive(c_op_nop, 32'h0, 16'h0, 32'h0, 1'b0, 5'd9, 32'h99);
    endtask

    // Writeback monitor: every wb_we pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && wb_we) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL wb_unexpected: got wb_addr=%0d wb_data=0x%08h, expected no writeback",
                         wb_addr, wb_data);
            end else begin
                wb_t e;
                e = sb_q.pop_front();
                chk("wb_addr", {27'h0, wb_addr}, {27'h0, e.addr});
                chk("wb_data", wb_data, e.data);
            end
        end
    end

    // Called just after a rising edge; returns just after a rising edge
    task automatic run_vec(input vec_t v);
        drive(v.op, v.reg1, v.off, v.reg2, v.we, v.waddr, v.ex_data);
        if (v.exp_wb_we) sb_q.push_back('{v.waddr, v.exp_wb_data});
        @(negedge clk);
        if (!tb_is_mem(v.op)) begin
            chk("stall_nonmem", {31'h0, stall_req}, 32'h0);
            @(posedge clk); #1;
        end else begin
            chk("stall_accept", {31'h0, stall_req}, 32'h1);
            chk("mem_req_idle", {31'h0, mem_req}, 32'h0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("mem_req_busy", {31'h0, mem_req}, 32'h1);
            chk("wb_bubble", {31'h0, wb_we}, 32'h0);
            chk("mem_addr", mem_addr, v.exp_addr);
            chk("mem_we", {31'h0, mem_we}, {31'h0, tb_is_store(v.op)});
            if (tb_is_store(v.op)) begin
                chk("mem_be", {28'h0, mem_be}, {28'h0, v.exp_be});
                chk("mem_wdata", mem_wdata, v.exp_wdata);
            end
            for (int c = 0; c < v.ack_dly; c++) begin
                chk("stall_busy", {31'h0, stall_req}, 32'h1);
                @(posedge clk); #1;
                @(negedge clk);
                chk("mem_req_hold", {31'h0, mem_req}, 32'h1);
                chk("mem_addr_hold", mem_addr, v.exp_addr);
            end
            mem_ack = 1'b1;
            mem_rdata = v.rdata;
            #1;
            chk("stall_ack", {31'h0, stall_req}, 32'h0);
            @(posedge clk); #1;
            mem_ack = 1'b0;
            mem_rdata = 32'h0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        drive_nop();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_wb_we", {31'h0, wb_we}, 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
        chk("rst_stall", {31'h0, stall_req}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        vecs.push_back(mk(c_op_add, 32'h0, 16'h0, 32'h0, 1'b1, 5'd3, 32'h5, 0, 32'h0,
                          32'h0, 4'h0, 32'h0, 1'b1, 32'h5));
        vecs.push_back(mk(c_op_sb, 32'h100, 16'h3, 32'hAB, 1'b0, 5'd0, 32'h0, 1, 32'h0,
                          32'h100, 4'b1000, 32'hABABABAB, 1'b0, 32'h0));
        vecs.push_back(mk(c_op_lb, 32'h200, 16'h2, 32'h0, 1'b1, 5'd4, 32'h0, 0, 32'h0080_0000,
                          32'h200, 4'h0, 32'h0, 1'b1, 32'hFFFFFF80));
        vecs.push_back(mk(c_op_lbu, 32'h200, 16'h2, 32'h0, 1'b1, 5'd5, 32'h0, 0, 32'h0080_0000,
                          32'h200, 4'h0, 32'h0, 1'b1, 32'h00000080));
        vecs.push_back(mk(c_op_lh, 32'h200, 16'h2, 32'h0, 1'b1, 5'd6, 32'h0, 0, 32'h8001_0000,
                          32'h200, 4'h0, 32'h0, 1'b1, 32'hFFFF8001));
        vecs.push_back(mk(c_op_lhu, 32'h1FE, 16'h4, 32'h0, 1'b1, 5'd10, 32'h0, 1, 32'h8001_1234,
                          32'h200, 4'h0, 32'h0, 1'b1, 32'h00008001));
        vecs.push_back(mk(c_op_lw, 32'h300, 16'hFFFC, 32'h0, 1'b1, 5'd11, 32'h0, 2, 32'hDEADBEEF,
                          32'h2FC, 4'h0, 32'h0, 1'b1, 32'hDEADBEEF));
        vecs.push_back(mk(c_op_add, 32'h0, 16'h0, 32'h0, 1'b1, 5'd31, 32'hFFFFFFFF, 0, 32'h0,
                          32'h0, 4'h0, 32'h0, 1'b1, 32'hFFFFFFFF));
        vecs.push_back(mk(c_op_lh, 32'h400, 16'h0, 32'h0, 1'b1, 5'd12, 32'h0, 0, 32'h1234_7FFE,
                          32'h400, 4'h0, 32'h0, 1'b1, 32'h00007FFE));
        vecs.push_back(mk(c_op_sh, 32'h400, 16'h2, 32'h1234CAFE, 1'b0, 5'd0, 32'h0, 0, 32'h0,
                          32'h400, 4'b1100, 32'hCAFECAFE, 1'b0, 32'h0));
        vecs.push_back(mk(c_op_sw, 32'h10, 16'h0, 32'h12345678, 1'b1, 5'd1, 32'h0, 3, 32'h0,
                          32'h10, 4'b1111, 32'h12345678, 1'b0, 32'h0));
        vecs.push_back(mk(c_op_lb, 32'h0, 16'h3, 32'h0, 1'b1, 5'd13, 32'h0, 0, 32'h7F00_0000,
                          32'h0, 4'h0, 32'h0, 1'b1, 32'h0000007F));
        vecs.push_back(mk(c_op_lb, 32'h0, 16'h1, 32'h0, 1'b1, 5'd14, 32'h0, 0, 32'h0000_C300,
                          32'h0, 4'h0, 32'h0, 1'b1, 32'hFFFFFFC3));
        vecs.push_back(mk(c_op_sb, 32'hFFFFFFFF, 16'h1, 32'h5A, 1'b0, 5'd0, 32'h0, 0, 32'h0,
                          32'h0, 4'b0001, 32'h5A5A5A5A, 1'b0, 32'h0));
        vecs.push_back(mk(c_op_lw, 32'h800, 16'h0, 32'h0, 1'b0, 5'd15, 32'h0, 0, 32'h11111111,
                          32'h800, 4'h0, 32'h0, 1'b0, 32'h0));
        vecs.push_back(mk(c_op_add, 32'h0, 16'h0, 32'h0, 1'b0, 5'd2, 32'h77, 0, 32'h0,
                          32'h0, 4'h0, 32'h0, 1'b0, 32'h0));
`ifndef MEM_ALIGN_CHECK_EN
        vecs.push_back(mk(c_op_lw, 32'h100, 16'h1, 32'h0, 1'b1, 5'd16, 32'h0, 0, 32'h55,
                          32'h100, 4'h0, 32'h0, 1'b1, 32'h55));
        vecs.push_back(mk(c_op_sh, 32'h100, 16'h3, 32'hBEEF, 1'b0, 5'd0, 32'h0, 0, 32'h0,
                          32'h100, 4'b1100, 32'hBEEFBEEF, 1'b0, 32'h0));
`endif

        foreach (vecs[i]) run_vec(vecs[i]);
        drive_nop();
        @(posedge clk); #1;

        // Timeout: no ack for TO BUSY cycles -> abort with bus_err pulse
        drive(c_op_lw, 32'h500, 16'h0, 32'h0, 1'b1, 5'd7, 32'h0);
        @(negedge clk);
        chk("to_stall_accept", {31'h0, stall_req}, 32'h1);
        for (int c = 0; c < TO; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("to_mem_req", {31'h0, mem_req}, 32'h1);
            chk("to_bus_err_low", {31'h0, bus_err}, 32'h0);
            chk("to_wb_we", {31'h0, wb_we}, 32'h0);
        end
        @(posedge clk); #1;
        drive_nop();
        @(negedge clk);
        chk("to_mem_req_drop", {31'h0, mem_req}, 32'h0);
        chk("to_bus_err", {31'h0, bus_err}, 32'h1);
        chk("to_wb_we_after", {31'h0, wb_we}, 32'h0);
        chk("to_stall_release", {31'h0, stall_req}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("to_bus_err_pulse", {31'h0, bus_err}, 32'h0);
        @(posedge clk); #1;

        // Ack in the final allowed BUSY cycle wins over timeout
        drive(c_op_lw, 32'h504, 16'h0, 32'h0, 1'b1, 5'd8, 32'h0);
        sb_q.push_back('{5'd8, 32'h0BADF00D});
        for (int c = 0; c < TO; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("lim_mem_req", {31'h0, mem_req}, 32'h1);
        end
        mem_ack = 1'b1;
        mem_rdata = 32'h0BADF00D;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        drive_nop();
        @(negedge clk);
        chk("lim_no_bus_err", {31'h0, bus_err}, 32'h0);
        chk("lim_mem_req_drop", {31'h0, mem_req}, 32'h0);
        @(posedge clk); #1;

        // Reset in the 2nd BUSY cycle, then a late ack in IDLE
        drive(c_op_sw, 32'h600, 16'h0, 32'h11223344, 1'b0, 5'd0, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive_nop();
        @(negedge clk);
        chk("rr_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rr_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rr_mem_addr", mem_addr, 32'h0);
        chk("rr_mem_be", {28'h0, mem_be}, 32'h0);
        chk("rr_mem_wdata", mem_wdata, 32'h0);
        chk("rr_wb_we", {31'h0, wb_we}, 32'h0);
        chk("rr_wb_addr", {27'h0, wb_addr}, 32'h0);
        chk("rr_wb_data", wb_data, 32'h0);
        chk("rr_bus_err", {31'h0, bus_err}, 32'h0);
        chk("rr_stall", {31'h0, stall_req}, 32'h0);
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        @(negedge clk);
        chk("late_ack_mem_req", {31'h0, mem_req}, 32'h0);
        chk("late_ack_wb_we", {31'h0, wb_we}, 32'h0);
        chk("late_ack_bus_err", {31'h0, bus_err}, 32'h0);
        @(posedge clk); #1;

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned word and halfword: no bus request, one-cycle bus_err
        for (int k = 0; k < 2; k++) begin
            if (k == 0) drive(c_op_lw, 32'h100, 16'h1, 32'h0, 1'b1, 5'd20, 32'h0);
            else        drive(c_op_sh, 32'h100, 16'h3, 32'h1234, 1'b0, 5'd0, 32'h0);
            @(negedge clk);
            chk("al_stall", {31'h0, stall_req}, 32'h0);
            chk("al_mem_req_idle", {31'h0, mem_req}, 32'h0);
            @(posedge clk); #1;
            drive_nop();
            @(negedge clk);
            chk("al_mem_req", {31'h0, mem_req}, 32'h0);
            chk("al_bus_err", {31'h0, bus_err}, 32'h1);
            chk("al_wb_we", {31'h0, wb_we}, 32'h0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("al_bus_err_pulse", {31'h0, bus_err}, 32'h0);
            chk("al_mem_req_after", {31'h0, mem_req}, 32'h0);
            @(posedge clk); #1;
        end
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", sb_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
